// File: rtl/pipe_hazard_fwd_if.sv
// Decode-slot, register-file and result-bus bundle for the hazard/forwarding unit.
// master = decode stage driving requests; slave = pipe_hazard_fwd.
interface pipe_hazard_fwd_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RAW   = 5,
  parameter int unsigned DEPTH = 3
);
  logic                    id_valid;
  logic [RAW-1:0]          id_rs;
  logic [RAW-1:0]          id_rt;
  logic                    id_use_rs;
  logic                    id_use_rt;
  logic                    id_wreg;
  logic                    id_m2reg;
  logic [RAW-1:0]          id_rn;
  logic                    id_flush;
  logic [XLEN-1:0]         rf_a;
  logic [XLEN-1:0]         rf_b;
  logic [DEPTH*XLEN-1:0]   stg_data;
  logic [XLEN-1:0]         da;
  logic [XLEN-1:0]         db;
  logic [2:0]              fwd_sel_a;
  logic [2:0]              fwd_sel_b;
  logic                    stall;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg,
           id_rn, id_flush, rf_a, rf_b, stg_data,
    input  da, db, fwd_sel_a, fwd_sel_b, stall
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_m2reg,
           id_rn, id_flush, rf_a, rf_b, stg_data,
    output da, db, fwd_sel_a, fwd_sel_b, stall
  );
endinterface

// File: rtl/pipe_hazard_fwd.sv
// Pipeline destination-tag tracker with operand forwarding and load-use stall.
// Define HAZ_PERF_EN to add saturating stall_cnt / fwd_cnt performance counters.
module pipe_hazard_fwd #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RAW   = 5,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned LDSTG = 2
) (
  input  logic               clock,
  input  logic               resetn,
  pipe_hazard_fwd_if.slave   bus
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        fwd_cnt
`endif
);

  logic [DEPTH:1] t_valid;
  logic [DEPTH:1] t_wreg;
  logic [DEPTH:1] t_ld;
  logic [RAW-1:0] t_rn [1:DEPTH];

  logic [3:0]     look_a;
  logic [3:0]     look_b;
  logic           haz_a;
  logic           haz_b;
  logic [2:0]     sel_a;
  logic [2:0]     sel_b;
  logic           stall;
  logic           load;

  // Returns {blocked, stage}; scanning oldest-to-youngest lets the youngest match win.
  function automatic logic [3:0] lookup(input logic [RAW-1:0] r);
    logic [3:0] res;
    res = '0;
    for (int unsigned k = DEPTH; k >= 1; k--) begin
      if (t_valid[k] && t_wreg[k] && (t_rn[k] == r) && (r != '0))
        res = {t_ld[k] && (k < LDSTG), 3'(k)};
    end
    return res;
  endfunction

  always_comb begin
    look_a = lookup(bus.id_rs);
    look_b = lookup(bus.id_rt);
    haz_a  = bus.id_use_rs && look_a[3];
    haz_b  = bus.id_use_rt && look_b[3];
    sel_a  = look_a[3] ? 3'd0 : look_a[2:0];
    sel_b  = look_b[3] ? 3'd0 : look_b[2:0];
    stall  = bus.id_valid && !bus.id_flush && (haz_a || haz_b);
    load   = bus.id_valid && !stall && !bus.id_flush;
  end

  always_comb begin
    bus.da = bus.rf_a;
    bus.db = bus.rf_b;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (sel_a == 3'(k)) bus.da = bus.stg_data[(k-1)*XLEN +: XLEN];
      if (sel_b == 3'(k)) bus.db = bus.stg_data[(k-1)*XLEN +: XLEN];
    end
  end

  assign bus.fwd_sel_a = sel_a;
  assign bus.fwd_sel_b = sel_b;
  assign bus.stall     = stall;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      t_valid <= '0;
      t_wreg  <= '0;
      t_ld    <= '0;
      for (int unsigned k = 1; k <= DEPTH; k++) t_rn[k] <= '0;
    end else begin
      t_valid[1] <= load;
      t_rn[1]    <= load ? bus.id_rn : '0;
      t_wreg[1]  <= load && bus.id_wreg;
      t_ld[1]    <= load && bus.id_m2reg;
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        t_valid[k] <= t_valid[k-1];
        t_rn[k]    <= t_rn[k-1];
        t_wreg[k]  <= t_wreg[k-1];
        t_ld[k]    <= t_ld[k-1];
      end
    end
  end

`ifdef HAZ_PERF_EN
  logic fwd_hit;
  assign fwd_hit = load && ((bus.id_use_rs && (sel_a != '0)) ||
                            (bus.id_use_rt && (sel_b != '0)));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (fwd_hit && (fwd_cnt != '1)) fwd_cnt <= fwd_cnt + 32'd1;
    end
  end
`endif

endmodule
